spi_sbus_master: RTL and testbench
==================================

Name: spi_sbus_master

Overview:
- System-bus master that configures and sequences one iCE40 UltraPlus SB_SPI hard IP over its SBWR/SBSTB/SBADR/SBDAT/SBACK interface.
- Runs the register init sequence after reset, then performs user-requested single-byte SPI transfers. Each transfer polls the status register and drives chip-select through SPICSR.
- Replaces hand-sequenced bus accesses from the Polyphony-generated bus driver. Sits between user logic and the SB_SPI bus port.

Parameters:
- BUS_ADDR74, 4'b0000, upper address nibble of the target SB_SPI instance (must match the IP's BUS_ADDR74).
- SPI_BR, 6'd12, value written to SPIBR[5:0] (SCK = clk/(SPI_BR+1)).
- CPOL, 1'b0, SPICR2[2].
- CPHA, 1'b0, SPICR2[1].
- CS_SEL, 2, index of the MCSN line driven for transfers (0..3).
- POLL_LIMIT, 1023, maximum status reads per wait before timeout.

Ports:
- clk  in  1  system clock (27 MHz)
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only when ready=1
- tx_data  in  8  byte to send; latched on accepted start
- cs_hold  in  1  latched on start; 1 = leave CS asserted after the byte
- ready  out  1  init complete and idle
- done  out  1  one-cycle pulse at transfer end
- rx_data  out  8  received byte; valid from done and held until next done
- error  out  1  set with done on timeout; cleared on next accepted start
- sb_stb  out  1  bus strobe (SBSTBi)
- sb_rw  out  1  1 = write (SBWRi)
- sb_addr  out  8  {BUS_ADDR74, offset}
- sb_wdata  out  8  write data (SBDATi)
- sb_rdata  in  8  read data (SBDATo)
- sb_ack  in  1  access acknowledge (SBACKo)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ready=0, done=0, error=0, rx_data=0, sb_stb=0, sb_rw=0, sb_addr=0, sb_wdata=0. FSM returns to INIT_CR0.
  - Reset mid-access drops sb_stb on the next edge. No completion of an in-flight transfer.
- Bus access rule:
  - Raise sb_stb with addr/rw/wdata stable. Hold them unchanged until the cycle sb_ack=1 is sampled.
  - Deassert sb_stb on the following cycle. For reads, capture sb_rdata in the ack cycle.
  - At least one idle cycle (stb=0) between accesses. No access without an ack ever overlaps another access.
- Register offsets (low nibble):
  - SPICR0=8, SPICR1=9, SPICR2=A, SPIBR=B, SPISR=C, SPITXDR=D, SPIRXDR=E, SPICSR=F.
  - SPISR bits: TRDY=bit4, RRDY=bit3.
- Init states, one write each, in order:
  - INIT_CR0 writes 8'h00.
  - INIT_CR1 writes 8'h80 (SPE).
  - INIT_CR2 writes {1'b1 MSTR, 1'b1 MCSH, 3'b000, CPOL, CPHA, 1'b0}.
  - INIT_BR writes {2'b00, SPI_BR}.
  - INIT_CSR writes 8'h0F (all CS high).
  - Then IDLE with ready=1.
- Transfer states:
  - IDLE: on start, latch tx_data and cs_hold, clear error.
    - CS already asserted (previous byte had cs_hold=1) -> POLL_TRDY.
    - Otherwise -> CS_ON.
  - CS_ON: write SPICSR = 4'hF with bit CS_SEL cleared.
  - POLL_TRDY: read SPISR, repeat until TRDY=1.
  - WR_TX: write SPITXDR = latched byte.
  - POLL_RRDY: read SPISR until RRDY=1.
  - RD_RX: read SPIRXDR into rx_data.
  - Then cs_hold ? FIN : CS_OFF.
  - CS_OFF: write SPICSR=8'h0F.
  - FIN: done=1 for one cycle, then IDLE.
- ready=0 in every state except IDLE. start while ready=0 is ignored (not queued).
- Poll counter: 10 bits, cleared on entry to each poll state, incremented per completed read.
  - Reaching POLL_LIMIT without the flag -> error=1 -> CS_OFF -> FIN.
  - rx_data is unchanged on timeout.
- CS-asserted tracker: set in CS_ON, cleared in CS_OFF and by reset.

Decomposition:
- Package spi_sbus_pkg holds:
  - register offset constants
  - SPISR bit indices
  - SPICSR all-high constant
  - FSM state enum
- One sub-module, sbus_access: single-access handshake engine (req/rw/addr/wdata in; busy, done pulse, rdata out). The top FSM issues one request per state.

Test Plan:
- Post-reset init: release rst with an IP model acking after 2 cycles -> writes observed in order: 08<=00, 09<=80, 0A<=C0, 0B<=0C, 0F<=0F. ready rises after the last ack.
- Single byte: model returns SPISR=10 then 08, RXDR=3C; start with tx_data=A5, cs_hold=0 -> writes 0F<=0B, 0D<=A5, 0F<=0F. done pulses with rx_data=3C, error=0.
- Burst: two starts (cs_hold=1 then 0), tx 11 and 22 -> exactly one CS_ON write (0F<=0B) before the first byte and one CS_OFF write after the second. No SPICSR access between the bytes.
- Slow ack: ack delayed 5 cycles -> addr/wdata/stb held constant for all 5 cycles. stb low for at least 1 cycle between accesses.
- Timeout: SPISR always 00, POLL_LIMIT=4 -> exactly 4 SR reads, then 0F<=0F, done with error=1, rx_data unchanged.
- Reset mid-transfer: assert rst during POLL_RRDY -> sb_stb=0 next cycle, ready=0. Full init sequence repeats after rst deasserts. start while busy is ignored.

Source files
------------

// File: rtl/spi_sbus_pkg.sv
// Shared constants and the controller state encoding for the SB_SPI bus master.
package spi_sbus_pkg;

   // SB_SPI register offsets (low address nibble)
   localparam logic [3:0] OFF_CR0  = 4'h8;
   localparam logic [3:0] OFF_CR1  = 4'h9;
   localparam logic [3:0] OFF_CR2  = 4'hA;
   localparam logic [3:0] OFF_BR   = 4'hB;
   localparam logic [3:0] OFF_SR   = 4'hC;
   localparam logic [3:0] OFF_TXDR = 4'hD;
   localparam logic [3:0] OFF_RXDR = 4'hE;
   localparam logic [3:0] OFF_CSR  = 4'hF;

   // SPISR flag positions
   localparam int SR_TRDY = 4;
   localparam int SR_RRDY = 3;

   // SPICSR value with every chip-select line deasserted (high)
   localparam logic [7:0] CSR_ALL_HIGH = 8'h0F;

   typedef enum logic [3:0] {
      ST_INIT_CR0,
      ST_INIT_CR1,
      ST_INIT_CR2,
      ST_INIT_BR,
      ST_INIT_CSR,
      ST_IDLE,
      ST_CS_ON,
      ST_POLL_TRDY,
      ST_WR_TX,
      ST_POLL_RRDY,
      ST_RD_RX,
      ST_CS_OFF,
      ST_FIN
   } state_t;

endpackage

// File: rtl/spi_sbus_master_sbus_access.sv
// Single-access system-bus handshake engine.
// Handshake: a request is taken when req=1, no access is in flight and the
// previous access did not finish in the previous cycle (that cycle is the
// mandatory stb-low gap). stb/rw/addr/wdata then stay frozen until sb_ack=1
// is sampled; stb drops on that edge, read data is captured from that same
// ack cycle and done pulses for exactly one cycle afterwards.
module sbus_access (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       rw,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       sb_stb,
   output logic       sb_rw,
   output logic [7:0] sb_addr,
   output logic [7:0] sb_wdata,
   input  logic [7:0] sb_rdata,
   input  logic       sb_ack
);

   assign busy = sb_stb;

   // Launch, hold and retire one bus access
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_stb   <= 1'b0;
         sb_rw    <= 1'b0;
         sb_addr  <= 8'h00;
         sb_wdata <= 8'h00;
         done     <= 1'b0;
         rdata    <= 8'h00;
      end else begin
         done <= 1'b0;
         if (sb_stb) begin
            if (sb_ack) begin
               sb_stb <= 1'b0;
               done   <= 1'b1;
               if (!sb_rw) rdata <= sb_rdata;
            end
         end else if (req && !done) begin
            sb_stb   <= 1'b1;
            sb_rw    <= rw;
            sb_addr  <= addr;
            sb_wdata <= wdata;
         end
      end
   end

endmodule

// File: rtl/spi_sbus_master.sv
// Sequencer for one SB_SPI hard IP: register init after reset, then
// single-byte transfers with status polling and SPICSR chip-select control.
module spi_sbus_master
   import spi_sbus_pkg::*;
#(
   parameter logic [3:0] BUS_ADDR74 = 4'b0000,
   parameter logic [5:0] SPI_BR     = 6'd12,
   parameter logic       CPOL       = 1'b0,
   parameter logic       CPHA       = 1'b0,
   parameter int         CS_SEL     = 2,
   parameter int         POLL_LIMIT = 1023
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] tx_data,
   input  logic       cs_hold,
   output logic       ready,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       error,
   output logic       sb_stb,
   output logic       sb_rw,
   output logic [7:0] sb_addr,
   output logic [7:0] sb_wdata,
   input  logic [7:0] sb_rdata,
   input  logic       sb_ack
);

   localparam logic [7:0] CR2_VAL    = {1'b1, 1'b1, 3'b000, CPOL, CPHA, 1'b0};
   localparam logic [7:0] BR_VAL     = {2'b00, SPI_BR};
   localparam logic [7:0] CS_ON_VAL  = CSR_ALL_HIGH & ~(8'h01 << CS_SEL);
   localparam logic [9:0] POLL_LAST  = 10'(POLL_LIMIT - 1);

   state_t     state, state_next;
   logic [7:0] tx_q;
   logic       hold_q;
   logic       cs_on_q;
   logic [9:0] poll_cnt;

   logic       need_acc, acc_rw, acc_busy, acc_done, poll_timeout;
   logic [3:0] acc_off;
   logic [7:0] acc_wdata, acc_rdata;

   sbus_access u_acc (
      .clk      (clk),
      .rst      (rst),
      .req      (need_acc & ~acc_busy),
      .rw       (acc_rw),
      .addr     ({BUS_ADDR74, acc_off}),
      .wdata    (acc_wdata),
      .busy     (acc_busy),
      .done     (acc_done),
      .rdata    (acc_rdata),
      .sb_stb   (sb_stb),
      .sb_rw    (sb_rw),
      .sb_addr  (sb_addr),
      .sb_wdata (sb_wdata),
      .sb_rdata (sb_rdata),
      .sb_ack   (sb_ack)
   );

   assign ready = (state == ST_IDLE);
   assign done  = (state == ST_FIN);

   // Next state and the single bus access each state issues
   always_comb begin
      state_next   = state;
      need_acc     = 1'b0;
      acc_rw       = 1'b1;
      acc_off      = OFF_CR0;
      acc_wdata    = 8'h00;
      poll_timeout = 1'b0;
      case (state)
         ST_INIT_CR0: begin
            need_acc = 1'b1; acc_off = OFF_CR0; acc_wdata = 8'h00;
            if (acc_done) state_next = ST_INIT_CR1;
         end
         ST_INIT_CR1: begin
            need_acc = 1'b1; acc_off = OFF_CR1; acc_wdata = 8'h80;
            if (acc_done) state_next = ST_INIT_CR2;
         end
         ST_INIT_CR2: begin
            need_acc = 1'b1; acc_off = OFF_CR2; acc_wdata = CR2_VAL;
            if (acc_done) state_next = ST_INIT_BR;
         end
         ST_INIT_BR: begin
            need_acc = 1'b1; acc_off = OFF_BR; acc_wdata = BR_VAL;
            if (acc_done) state_next = ST_INIT_CSR;
         end
         ST_INIT_CSR: begin
            need_acc = 1'b1; acc_off = OFF_CSR; acc_wdata = CSR_ALL_HIGH;
            if (acc_done) state_next = ST_IDLE;
         end
         ST_IDLE: begin
            if (start) state_next = cs_on_q ? ST_POLL_TRDY : ST_CS_ON;
         end
         ST_CS_ON: begin
            need_acc = 1'b1; acc_off = OFF_CSR; acc_wdata = CS_ON_VAL;
            if (acc_done) state_next = ST_POLL_TRDY;
         end
         ST_POLL_TRDY: begin
            need_acc = 1'b1; acc_rw = 1'b0; acc_off = OFF_SR;
            if (acc_done) begin
               if (acc_rdata[SR_TRDY]) state_next = ST_WR_TX;
               else if (poll_cnt == POLL_LAST) begin
                  poll_timeout = 1'b1;
                  state_next   = ST_CS_OFF;
               end
            end
         end
         ST_WR_TX: begin
            need_acc = 1'b1; acc_off = OFF_TXDR; acc_wdata = tx_q;
            if (acc_done) state_next = ST_POLL_RRDY;
         end
         ST_POLL_RRDY: begin
            need_acc = 1'b1; acc_rw = 1'b0; acc_off = OFF_SR;
            if (acc_done) begin
               if (acc_rdata[SR_RRDY]) state_next = ST_RD_RX;
               else if (poll_cnt == POLL_LAST) begin
                  poll_timeout = 1'b1;
                  state_next   = ST_CS_OFF;
               end
            end
         end
         ST_RD_RX: begin
            need_acc = 1'b1; acc_rw = 1'b0; acc_off = OFF_RXDR;
            if (acc_done) state_next = hold_q ? ST_FIN : ST_CS_OFF;
         end
         ST_CS_OFF: begin
            need_acc = 1'b1; acc_off = OFF_CSR; acc_wdata = CSR_ALL_HIGH;
            if (acc_done) state_next = ST_FIN;
         end
         ST_FIN:  state_next = ST_IDLE;
         default: state_next = ST_INIT_CR0;
      endcase
   end

   // State register plus transfer datapath (latches, poll count, CS tracker)
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_INIT_CR0;
         tx_q     <= 8'h00;
         hold_q   <= 1'b0;
         cs_on_q  <= 1'b0;
         poll_cnt <= 10'd0;
         rx_data  <= 8'h00;
         error    <= 1'b0;
      end else begin
         state <= state_next;
         // any state change clears the count, so each poll state starts at 0
         if (state_next != state) poll_cnt <= 10'd0;
         else if (acc_done && (state == ST_POLL_TRDY || state == ST_POLL_RRDY))
            poll_cnt <= poll_cnt + 10'd1;
         if (state == ST_IDLE && start) begin
            tx_q   <= tx_data;
            hold_q <= cs_hold;
            error  <= 1'b0;
         end
         if (poll_timeout) error <= 1'b1;
         if (state == ST_CS_ON  && acc_done) cs_on_q <= 1'b1;
         if (state == ST_CS_OFF && acc_done) cs_on_q <= 1'b0;
         if (state == ST_RD_RX  && acc_done) rx_data <= acc_rdata;
      end
   end

endmodule

// File: tb/tb_spi_sbus_master.sv
// Self-checking bench for spi_sbus_master: SB_SPI bus model, access and
// done scoreboards, bus-protocol monitor and directed transfer scenarios.
module tb_spi_sbus_master;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       cs_hold = 1'b0;
   logic       ready, done, error;
   logic [7:0] rx_data;
   logic       sb_stb, sb_rw;
   logic [7:0] sb_addr, sb_wdata;
   logic [7:0] sb_rdata = 8'h00;
   logic       sb_ack = 1'b0;

   int checks = 0;
   int failures = 0;

   // expected bus accesses {rw, addr, wdata} and done events {error, rx_data}
   logic [16:0] exp_q[$];
   logic [8:0]  exp_done_q[$];

   // bus model controls
   int         ack_delay = 2;
   int         ack_cnt = 0;
   logic [7:0] sr_q[$];
   logic [7:0] sr_default = 8'h00;
   logic [7:0] rx_val = 8'h00;

   always #5 clk = ~clk;

   spi_sbus_master #(.POLL_LIMIT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .tx_data  (tx_data),
      .cs_hold  (cs_hold),
      .ready    (ready),
      .done     (done),
      .rx_data  (rx_data),
      .error    (error),
      .sb_stb   (sb_stb),
      .sb_rw    (sb_rw),
      .sb_addr  (sb_addr),
      .sb_wdata (sb_wdata),
      .sb_rdata (sb_rdata),
      .sb_ack   (sb_ack)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic exp_wr(input logic [3:0] off, input logic [7:0] data);
      exp_q.push_back({1'b1, 4'h0, off, data});
   endtask

   task automatic exp_rd(input logic [3:0] off);
      exp_q.push_back({1'b0, 4'h0, off, 8'h00});
   endtask

   task automatic exp_init();
      exp_wr(4'h8, 8'h00);
      exp_wr(4'h9, 8'h80);
      exp_wr(4'hA, 8'hC0);
      exp_wr(4'hB, 8'h0C);
      exp_wr(4'hF, 8'h0F);
   endtask

   // SB_SPI bus model: ack after ack_delay cycles of strobe, data set with ack
   always @(posedge clk) begin
      if (sb_stb && !sb_ack) begin
         if (ack_cnt + 1 >= ack_delay) begin
            sb_ack  <= 1'b1;
            ack_cnt <= 0;
            if (sb_addr[3:0] == 4'hC) begin
               if (sr_q.size() > 0) sb_rdata <= sr_q.pop_front();
               else sb_rdata <= sr_default;
            end else if (sb_addr[3:0] == 4'hE) sb_rdata <= rx_val;
            else sb_rdata <= 8'h00;
         end else begin
            ack_cnt <= ack_cnt + 1;
         end
      end else begin
         sb_ack  <= 1'b0;
         ack_cnt <= 0;
      end
   end

   // Monitor: scoreboard pops on acked accesses and done pulses, plus
   // protocol checks (hold while strobed, strobe drop after ack)
   initial begin
      logic [16:0] e;
      logic [8:0]  d;
      logic        stb_prev = 1'b0;
      logic        ack_prev = 1'b0;
      logic        viol = 1'b0;
      logic [16:0] held = '0;
      forever begin
         @(negedge clk);
         if (ack_prev) check("stb_drop", sb_stb, 1'b0);
         if (sb_stb && !stb_prev) begin
            held = {sb_rw, sb_addr, sb_wdata};
            viol = 1'b0;
         end else if (sb_stb && stb_prev) begin
            if ({sb_rw, sb_addr, sb_wdata} !== held) viol = 1'b1;
         end else if (!sb_stb && stb_prev) begin
            check("bus_hold", viol, 1'b0);
         end
         if (!rst && sb_stb && sb_ack) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_access actual=rw%0d_%0h_%0h required=none", sb_rw, sb_addr, sb_wdata);
            end else begin
               e = exp_q.pop_front();
               check("access_rw_addr", {sb_rw, sb_addr}, e[16:8]);
               if (e[16]) check("access_wdata", sb_wdata, e[7:0]);
            end
         end
         if (done) begin
            if (exp_done_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               d = exp_done_q.pop_front();
               check("done_error", error, d[8]);
               check("done_rx_data", rx_data, d[7:0]);
            end
         end
         ack_prev = sb_stb && sb_ack;
         stb_prev = sb_stb;
      end
   end

   task automatic wait_ready(input string name);
      bit seen = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (ready) begin
            seen = 1;
            break;
         end
      end
      check(name, seen, 1'b1);
   endtask

   task automatic pulse_start(input logic [7:0] tx, input logic hold);
      start   = 1'b1;
      tx_data = tx;
      cs_hold = hold;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] tx, input logic hold);
      bit seen = 0;
      wait_ready("xfer_ready");
      pulse_start(tx, hold);
      for (int i = 0; i < 3000; i++) begin
         if (done) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      check("xfer_done_seen", seen, 1'b1);
      @(negedge clk);
   endtask

   initial begin
      bit seen_tx;
      bit hit;
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", ready, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_stb", sb_stb, 1'b0);
      check("rst_rw", sb_rw, 1'b0);
      check("rst_addr", sb_addr, 8'h00);
      check("rst_wdata", sb_wdata, 8'h00);

      // init sequence
      exp_init();
      rst = 1'b0;
      wait_ready("init_ready");
      check("init_all_acked", exp_q.size(), 0);

      // single byte, CS toggled around it
      sr_q = '{8'h10, 8'h08};
      rx_val = 8'h3C;
      exp_wr(4'hF, 8'h0B); exp_rd(4'hC); exp_wr(4'hD, 8'hA5);
      exp_rd(4'hC); exp_rd(4'hE); exp_wr(4'hF, 8'h0F);
      exp_done_q.push_back({1'b0, 8'h3C});
      xfer(8'hA5, 1'b0);

      // burst: CS held across two bytes, no SPICSR access in between
      sr_q = '{8'h10, 8'h08};
      rx_val = 8'h5A;
      exp_wr(4'hF, 8'h0B); exp_rd(4'hC); exp_wr(4'hD, 8'h11);
      exp_rd(4'hC); exp_rd(4'hE);
      exp_done_q.push_back({1'b0, 8'h5A});
      xfer(8'h11, 1'b1);
      sr_q = '{8'h10, 8'h08};
      rx_val = 8'h77;
      exp_rd(4'hC); exp_wr(4'hD, 8'h22); exp_rd(4'hC); exp_rd(4'hE);
      exp_wr(4'hF, 8'h0F);
      exp_done_q.push_back({1'b0, 8'h77});
      xfer(8'h22, 1'b0);

      // slow ack, and TRDY arriving on read POLL_LIMIT-1 (no timeout)
      ack_delay = 5;
      sr_q = '{8'h00, 8'h00, 8'h10, 8'h08};
      rx_val = 8'hC3;
      exp_wr(4'hF, 8'h0B); exp_rd(4'hC); exp_rd(4'hC); exp_rd(4'hC);
      exp_wr(4'hD, 8'h99); exp_rd(4'hC); exp_rd(4'hE); exp_wr(4'hF, 8'h0F);
      exp_done_q.push_back({1'b0, 8'hC3});
      xfer(8'h99, 1'b0);

      // timeout: SPISR never ready -> exactly 4 reads, CS off, error, rx kept
      ack_delay = 2;
      sr_default = 8'h00;
      rx_val = 8'hAA;
      exp_wr(4'hF, 8'h0B);
      for (int i = 0; i < 4; i++) exp_rd(4'hC);
      exp_wr(4'hF, 8'h0F);
      exp_done_q.push_back({1'b1, 8'hC3});
      xfer(8'h44, 1'b0);

      // reset during POLL_RRDY
      sr_q = '{8'h10};
      exp_wr(4'hF, 8'h0B); exp_rd(4'hC); exp_wr(4'hD, 8'h55);
      wait_ready("mid_ready");
      pulse_start(8'h55, 1'b0);
      seen_tx = 0;
      hit = 0;
      for (int i = 0; i < 3000; i++) begin
         if (sb_stb && sb_addr == 8'h0D) seen_tx = 1;
         else if (seen_tx && sb_stb && sb_addr == 8'h0C) begin
            hit = 1;
            break;
         end
         @(negedge clk);
      end
      check("mid_poll_reached", hit, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_stb", sb_stb, 1'b0);
      check("mid_rst_ready", ready, 1'b0);
      check("mid_rst_queue", exp_q.size(), 0);
      sr_q.delete();
      exp_init();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pulse_start(8'hEE, 1'b1);   // ignored: ready is low during init
      wait_ready("reinit_ready");
      check("reinit_all_acked", exp_q.size(), 0);
      repeat (40) @(negedge clk);

      // CS tracker cleared by reset: next transfer asserts CS again
      sr_q = '{8'h10, 8'h08};
      rx_val = 8'h66;
      exp_wr(4'hF, 8'h0B); exp_rd(4'hC); exp_wr(4'hD, 8'h5A);
      exp_rd(4'hC); exp_rd(4'hE); exp_wr(4'hF, 8'h0F);
      exp_done_q.push_back({1'b0, 8'h66});
      xfer(8'h5A, 1'b0);
      repeat (20) @(negedge clk);
      check("final_access_queue", exp_q.size(), 0);
      check("final_done_queue", exp_done_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
